// File: rtl/receive_data_word_pkg.sv
// Shared serial-link definitions: UART state encoding, word geometry and the
// byte-placement helper used by the receive-side word assembler.
package receive_data_word_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  localparam int BYTES_PER_WORD       = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Byte idx 0 lands in the top lane of the 24-bit holding register.
  function automatic logic [23:0] place_byte(input logic [23:0] held,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  data);
    logic [23:0] res;
    res = held;
    case (idx)
      2'd0:    res[23:16] = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[7:0]   = data;
      default: res        = held;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/receive_data_word_if.sv
// Receive-side link bundle: serial line in, assembled word and status out.
interface receive_data_word_if;
  import receive_data_word_pkg::*;

  logic        rxd_in;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  modport master (output rxd_in, input data_out, input data_valid,
                  input frame_err, input busy);
  modport slave  (input rxd_in, output data_out, output data_valid,
                  output frame_err, output busy);
endinterface

// File: rtl/receive_data_word_uart_rxd.sv
// 8N1 byte receiver: two-flop synchroniser, baud counter and byte FSM.
module uart_rxd
  import receive_data_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_byte,
  output logic       byte_done,
  output logic       frame_err,
  output logic       active,
  output logic       start_det
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_r;
  uart_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             byte_done_r;
  logic             frame_err_r;
  logic             rx_s;

  assign rx_s      = sync_r[1];
  assign data_byte = shift_r;
  assign byte_done = byte_done_r;
  assign frame_err = frame_err_r;
  assign active    = (state_r != UART_IDLE);
  assign start_det = (state_r == UART_IDLE) && !rx_s;

  // Synchroniser, bit timing and frame decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r      <= 2'b11;
      state_r     <= UART_IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'd0;
      byte_done_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      sync_r      <= {sync_r[0], rxd};
      byte_done_r <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        UART_IDLE: begin
          cnt_r     <= '0;
          bit_idx_r <= 3'd0;
          state_r   <= rx_s ? UART_IDLE : UART_START;
        end
        UART_START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r   <= '0;
            // A line back high at mid start bit is a glitch, not a frame.
            state_r <= rx_s ? UART_IDLE : UART_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        UART_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r     <= '0;
            shift_r   <= {rx_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            state_r   <= (bit_idx_r == 3'd7) ? UART_STOP : UART_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        UART_STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r       <= '0;
            state_r     <= UART_IDLE;
            byte_done_r <= rx_s;
            frame_err_r <= !rx_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: state_r <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/receive_data_word.sv
// Receive-side word assembler: packs four UART bytes, MSB byte first, into a
// 32-bit word with a one-cycle valid strobe; stale partial words time out.
module receive_data_word
  import receive_data_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                clk,
  input  logic                rst,
  receive_data_word_if.slave  bus
);

  localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W      = $clog2(TMO_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [1:0]       IDX_LAST = 2'(BYTES_PER_WORD - 1);

  logic [7:0]       byte_s;
  logic             byte_done_s;
  logic             frame_err_s;
  logic             rx_active_s;
  logic             start_det_s;

  logic [1:0]       idx_r;
  logic [23:0]      held_r;
  logic [31:0]      data_out_r;
  logic             data_valid_r;
  logic             busy_r;
  logic [TMO_W-1:0] tmo_r;

  uart_rxd #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rxd (
    .clk       (clk),
    .rst       (rst),
    .rxd       (bus.rxd_in),
    .data_byte (byte_s),
    .byte_done (byte_done_s),
    .frame_err (frame_err_s),
    .active    (rx_active_s),
    .start_det (start_det_s)
  );

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.frame_err  = frame_err_s;
  assign bus.busy       = busy_r;

  // Word assembly, inter-byte timeout and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r        <= 2'd0;
      held_r       <= 24'd0;
      data_out_r   <= 32'd0;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      tmo_r        <= '0;
    end else begin
      data_valid_r <= 1'b0;
      busy_r       <= (idx_r != 2'd0) || rx_active_s;
      if (frame_err_s) begin
        idx_r <= 2'd0;
        tmo_r <= '0;
      end else if (byte_done_s) begin
        tmo_r <= '0;
        if (idx_r == IDX_LAST) begin
          data_out_r   <= {held_r, byte_s};
          data_valid_r <= 1'b1;
          idx_r        <= 2'd0;
        end else begin
          held_r <= place_byte(held_r, idx_r, byte_s);
          idx_r  <= idx_r + 2'd1;
        end
      end else if (start_det_s || rx_active_s) begin
        // Start detection beats a coincident expiry and keeps the index.
        tmo_r <= '0;
      end else if (idx_r != 2'd0) begin
        if (tmo_r == TMO_LAST) begin
          idx_r <= 2'd0;
          tmo_r <= '0;
        end else begin
          tmo_r <= tmo_r + TMO_W'(1);
        end
      end else begin
        tmo_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_receive_data_word.sv
// Directed bench for receive_data_word at 16 clocks per bit.
module tb_receive_data_word;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] vq[$];
  int          fe_cnt = 0;
  logic        valid_prev = 1'b0;
  logic        busy_after_valid = 1'b1;

  receive_data_word_if bus();

  receive_data_word #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (valid_prev) busy_after_valid = bus.busy;
    valid_prev = bus.data_valid;
    if (bus.data_valid) vq.push_back(bus.data_out);
    if (bus.frame_err) fe_cnt = fe_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    bus.rxd_in = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    bus.rxd_in = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8],  1'b1);
    send_byte(w[7:0],   1'b1);
  endtask

  initial begin
    logic [7:0] rb;
    bus.rxd_in = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_data_out", bus.data_out, 32'h0);
    check_val("rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check_val("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_word(32'hDEADBEEF);
    repeat (6) @(negedge clk);
    check_val("w1_count", 32'(vq.size()), 32'd1);
    check_val("w1_value", vq[0], 32'hDEADBEEF);
    check_val("w1_busy_after", {31'd0, busy_after_valid}, 32'd0);
    check_val("w1_no_ferr", 32'(fe_cnt), 32'd0);

    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    repeat (6) @(negedge clk);
    check_val("w2_count", 32'(vq.size()), 32'd3);
    check_val("w2_first", vq[1], 32'h01234567);
    check_val("w2_second", vq[2], 32'h89ABCDEF);
    check_val("w2_no_ferr", 32'(fe_cnt), 32'd0);

    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    send_word(32'hCAFEBABE);
    repeat (6) @(negedge clk);
    check_val("ferr_count", 32'(fe_cnt), 32'd1);
    check_val("ferr_valid_count", 32'(vq.size()), 32'd4);
    check_val("ferr_next_word", vq[3], 32'hCAFEBABE);

    bus.rxd_in = 1'b0;
    repeat (6) @(negedge clk);
    bus.rxd_in = 1'b1;
    repeat (40) @(negedge clk);
    check_val("glitch_busy", {31'd0, bus.busy}, 32'd0);
    check_val("glitch_no_valid", 32'(vq.size()), 32'd4);
    check_val("glitch_no_ferr", 32'(fe_cnt), 32'd1);

    send_byte(8'hAA, 1'b1);
    repeat (21 * CPB) @(negedge clk);
    check_val("tmo_busy", {31'd0, bus.busy}, 32'd0);
    send_word(32'h01020304);
    repeat (6) @(negedge clk);
    check_val("tmo_count", 32'(vq.size()), 32'd5);
    check_val("tmo_value", vq[4], 32'h01020304);

    send_byte(8'h5A, 1'b1);
    rb = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rb[i]);
    bus.rxd_in = rb[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("mid_rst_data_out", bus.data_out, 32'h0);
    check_val("mid_rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check_val("mid_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    check_val("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    bus.rxd_in = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_word(32'h5A5A5A5A);
    repeat (6) @(negedge clk);
    check_val("post_rst_count", 32'(vq.size()), 32'd6);
    check_val("post_rst_value", vq[5], 32'h5A5A5A5A);
    check_val("post_rst_data_out", bus.data_out, 32'h5A5A5A5A);
    check_val("final_ferr", 32'(fe_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/receive_data_word.md
# receive_data_word

Receive-side word assembler for the serial link: samples the asynchronous UART RX line, decodes 8N1 frames, and packs four consecutive bytes (MSB byte first) into one 32-bit word presented to the cipher core with a one-cycle valid strobe. It is the far-end counterpart of the transmit-side word splitter: it consumes exactly the byte stream that block produces and hands the cipher engine the plaintext/ciphertext word it expects.

## Interface
- CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 8.
- TIMEOUT_BITS, default 20, idle bit-times allowed between bytes of one word before the partial word is discarded.
- clk  input  1  system clock.
- rst  input  1  reset rst, synchronous, active-high.
- rxd_in  input  1  asynchronous UART RX line, idle high.
- data_out  output  32  last completed word; byte 0 received lands in [31:24], byte 3 in [7:0].
- data_valid  output  1  one-cycle pulse when data_out is updated.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- busy  output  1  high while a partial word (1–3 bytes) is held or a frame is in progress.

## Operation
- rxd_in passes through a 2-flop synchroniser (reset to 1) before any use.
- Byte receiver FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: synchronised line falls to 0 → START, bit counter cleared.
  - START: at CLKS_PER_BIT/2 (integer divide) re-sample; 0 → DATA, 1 → IDLE (glitch rejected, no error).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into an 8-bit register.
  - STOP: sample after CLKS_PER_BIT; 1 → byte_done pulse; 0 → frame_err pulse. Both return to IDLE.
- Word assembler: 2-bit byte index plus 24-bit holding register.
  - byte_done at index 0..2: store byte at position [31-8·idx -: 8], index+1.
  - byte_done at index 3: data_out ← {held[31:8], byte}, data_valid pulse, index → 0.
  - frame_err: index → 0, partial word dropped, data_out unchanged.
  - Inter-byte timeout: counter runs in IDLE while index ≠ 0; reaching TIMEOUT_BITS·CLKS_PER_BIT cycles resets index to 0 (no pulse). Cleared on every start-bit detection.
- data_out holds its value until the next complete word; there is no backpressure, and the consumer must sample on data_valid.
- busy = (index ≠ 0) or (FSM ≠ IDLE).

## Timing
- Reset values: data_out = 0, data_valid = 0, frame_err = 0, busy = 0, FSM = IDLE, index = 0, synchroniser = 11.
- Falling edge to START entry: 2 cycles of synchroniser latency plus 1 cycle.
- Stop-bit sample point: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after START entry.
- byte_done/frame_err: 1 cycle after the stop sample. data_valid: 1 cycle after the 4th byte_done, so 2 cycles after the 4th stop sample.
- Back-to-back frames: the next falling edge may arrive immediately after the stop-bit centre. The FSM is in IDLE by then, so no bytes are lost.
- Timeout expiry and start detection in the same cycle: the start wins and the timeout is cleared; index is kept.
- rst mid-frame or mid-word: everything returns to reset values on the next edge. No pulse is emitted.

## Structure
- Shared package or include: UART state encodings (IDLE, START, DATA, STOP), BYTES_PER_WORD = 4, default CLKS_PER_BIT constant, also reused by the transmit side.
- One sub-module, uart_rxd: synchroniser, baud counter and byte FSM. Outputs byte, byte_done and frame_err.
- The top level contains only the word assembler and timeout counter.

## Test plan
- CLKS_PER_BIT = 16; send bytes DE AD BE EF back-to-back -> single data_valid pulse, data_out = 0xDEADBEEF; busy low 1 cycle later.
- Two words 0x01234567 then 0x89ABCDEF with zero idle gap -> two data_valid pulses, values in order, no frame_err.
- Send 0x11, 0x22, then 0x33 with stop bit = 0, then 0xCA FE BA BE -> one frame_err, no valid for the broken word, then data_out = 0xCAFEBABE.
- Line low for 6 cycles (< 8) then high -> no byte, busy returns 0, no pulses.
- Send 0xAA, idle 21 bit-times, then 0x01 02 03 04 -> partial 0xAA discarded, data_out = 0x01020304.
- Assert rst during bit 4 of byte 2 -> outputs at reset values; a subsequent 0x5A5A5A5A is received correctly.
